// File: rtl/ofs_plat_avalon_mem_sink_responder.sv
// Avalon-MM sink endpoint backed by an on-chip word array.
// Services burst reads/writes, echoes request user, flags out-of-range bases with SLVERR.
module ofs_plat_avalon_mem_sink_responder #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int USER_WIDTH      = 4,
  parameter int MEM_ADDR_WIDTH  = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       waitrequest,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  input  logic                       read,
  input  logic                       write,
  input  logic [DATA_WIDTH-1:0]      writedata,
  input  logic [DATA_WIDTH/8-1:0]    byteenable,
  input  logic [USER_WIDTH-1:0]      user,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       readdatavalid,
  output logic [1:0]                 response,
  output logic [USER_WIDTH-1:0]      readresponseuser,
  output logic                       writeresponsevalid,
  output logic [1:0]                 writeresponse,
  output logic [USER_WIDTH-1:0]      writeresponseuser
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** MEM_ADDR_WIDTH;
  localparam int SUM_W    = (MEM_ADDR_WIDTH > BURST_CNT_WIDTH) ? MEM_ADDR_WIDTH : BURST_CNT_WIDTH;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_BURST = 2'd1;
  localparam logic [1:0] ST_RD_BURST = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE = BURST_CNT_WIDTH'(1);

  logic [1:0]                 r_state;
  logic                       r_waitrequest;
  logic [MEM_ADDR_WIDTH-1:0]  r_base;
  logic [BURST_CNT_WIDTH-1:0] r_bc;
  logic [BURST_CNT_WIDTH-1:0] r_cnt;
  logic [USER_WIDTH-1:0]      r_user;
  logic                       r_oor;
  logic                       r_rdvalid;
  logic [1:0]                 r_response;
  logic [USER_WIDTH-1:0]      r_rd_user;
  logic                       r_wrvalid;
  logic [1:0]                 r_wresp;
  logic [USER_WIDTH-1:0]      r_wr_user;

  logic                       w_addr_oor;
  logic [BURST_CNT_WIDTH-1:0] w_bc;
  logic                       w_cmd_wr;
  logic                       w_cmd_rd;
  logic                       w_beat_wr;
  logic                       w_last_wr;
  logic                       w_rd_more;
  logic [SUM_W-1:0]           w_burst_sum;
  logic [MEM_ADDR_WIDTH-1:0]  w_mem_addr;
  logic                       w_mem_we;
  logic                       w_mem_re;
  logic [DATA_WIDTH-1:0]      w_mem_q;

  // Only the base address is range-checked; later beats wrap inside the array.
  generate
    if (MEM_ADDR_WIDTH < ADDR_WIDTH) begin : g_range
      assign w_addr_oor = |address[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
    end else begin : g_no_range
      assign w_addr_oor = 1'b0;
    end
  endgenerate

  assign w_bc        = (burstcount == '0) ? BC_ONE : burstcount;
  assign w_cmd_wr    = (r_state == ST_IDLE) && write && !r_waitrequest;
  assign w_cmd_rd    = (r_state == ST_IDLE) && read && !write && !r_waitrequest;
  assign w_beat_wr   = (r_state == ST_WR_BURST) && write && !r_waitrequest;
  assign w_last_wr   = w_beat_wr && (r_cnt == (r_bc - BC_ONE));
  assign w_rd_more   = (r_state == ST_RD_BURST) && (r_cnt < r_bc);
  assign w_burst_sum = SUM_W'(r_base) + SUM_W'(r_cnt);
  assign w_mem_addr  = (r_state == ST_IDLE) ? address[MEM_ADDR_WIDTH-1:0]
                                            : w_burst_sum[MEM_ADDR_WIDTH-1:0];
  assign w_mem_we    = (w_cmd_wr && !w_addr_oor) || (w_beat_wr && !r_oor);
  assign w_mem_re    = w_cmd_rd || w_rd_more;

  // One array per byte lane so byteenable maps onto per-lane write enables.
  generate
    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH];
      logic [7:0] r_lane_q;
      always_ff @(posedge clk) begin
        if (w_mem_we && byteenable[gi]) begin
          r_lane[w_mem_addr] <= writedata[gi*8 +: 8];
        end
        if (w_mem_re) begin
          r_lane_q <= r_lane[w_mem_addr];
        end
      end
      assign w_mem_q[gi*8 +: 8] = r_lane_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_waitrequest <= 1'b1;
      r_base        <= '0;
      r_bc          <= BC_ONE;
      r_cnt         <= '0;
      r_user        <= '0;
      r_oor         <= 1'b0;
      r_rdvalid     <= 1'b0;
      r_response    <= RESP_OKAY;
      r_rd_user     <= '0;
      r_wrvalid     <= 1'b0;
      r_wresp       <= RESP_OKAY;
      r_wr_user     <= '0;
    end else begin
      r_rdvalid <= 1'b0;
      r_wrvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_waitrequest <= 1'b0;
          if (w_cmd_wr || w_cmd_rd) begin
            r_base <= address[MEM_ADDR_WIDTH-1:0];
            r_bc   <= w_bc;
            r_user <= user;
            r_oor  <= w_addr_oor;
            r_cnt  <= BC_ONE;
          end
          if (w_cmd_wr) begin
            if (w_bc == BC_ONE) begin
              r_wrvalid <= 1'b1;
              r_wresp   <= w_addr_oor ? RESP_SLVERR : RESP_OKAY;
              r_wr_user <= user;
            end else begin
              r_state <= ST_WR_BURST;
            end
          end else if (w_cmd_rd) begin
            r_state       <= ST_RD_BURST;
            r_waitrequest <= 1'b1;
            r_rdvalid     <= 1'b1;
            r_response    <= w_addr_oor ? RESP_SLVERR : RESP_OKAY;
            r_rd_user     <= user;
          end
        end
        ST_WR_BURST: begin
          if (w_last_wr) begin
            r_state   <= ST_IDLE;
            r_wrvalid <= 1'b1;
            r_wresp   <= r_oor ? RESP_SLVERR : RESP_OKAY;
            r_wr_user <= r_user;
          end else if (w_beat_wr) begin
            r_cnt <= r_cnt + BC_ONE;
          end
        end
        ST_RD_BURST: begin
          // waitrequest stays high until the last beat has been presented.
          if (w_rd_more) begin
            r_rdvalid <= 1'b1;
            r_cnt     <= r_cnt + BC_ONE;
          end else begin
            r_state       <= ST_IDLE;
            r_waitrequest <= 1'b0;
            r_response    <= RESP_OKAY;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_waitrequest <= 1'b0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!((r_state == ST_IDLE) && !r_waitrequest && read && write))
        else $fatal(1, "read and write asserted together in IDLE");
      assert (!((w_cmd_wr || w_cmd_rd) && (burstcount == '0)))
        else $fatal(1, "burstcount of zero accepted");
      assert (!((r_state == ST_WR_BURST) && read))
        else $fatal(1, "read asserted during a write burst");
    end
  end

  assign waitrequest        = r_waitrequest;
  assign readdatavalid      = r_rdvalid;
  assign readdata           = (r_rdvalid && !r_response[1]) ? w_mem_q : '0;
  assign response           = r_response;
  assign readresponseuser   = r_rd_user;
  assign writeresponsevalid = r_wrvalid;
  assign writeresponse      = r_wresp;
  assign writeresponseuser  = r_wr_user;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_sink_responder.sv
// Directed bench for the Avalon-MM sink responder: bursts, byte masks, wrap,
// out-of-range SLVERR, stalled write bursts and reset during a read burst.
module tb_ofs_plat_avalon_mem_sink_responder;

  localparam int AW = 27;
  localparam int DW = 64;
  localparam int BW = 7;
  localparam int UW = 4;
  localparam int MW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          waitrequest;
  logic [AW-1:0] address = '0;
  logic [BW-1:0] burstcount = 7'd1;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic [7:0]    byteenable = '0;
  logic [UW-1:0] user = '0;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic [1:0]    response;
  logic [UW-1:0] readresponseuser;
  logic          writeresponsevalid;
  logic [1:0]    writeresponse;
  logic [UW-1:0] writeresponseuser;

  int n_checks = 0;
  int n_errors = 0;
  int wresp_seen = 0;
  int rd_seen = 0;

  logic [DW-1:0] wbuf [8];
  logic [DW-1:0] ebuf [8];

  always #5 clk = ~clk;

  ofs_plat_avalon_mem_sink_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
    .USER_WIDTH(UW), .MEM_ADDR_WIDTH(MW)
  ) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest),
    .address(address), .burstcount(burstcount), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .user(user),
    .readdata(readdata), .readdatavalid(readdatavalid), .response(response),
    .readresponseuser(readresponseuser), .writeresponsevalid(writeresponsevalid),
    .writeresponse(writeresponse), .writeresponseuser(writeresponseuser)
  );

  always @(negedge clk) begin
    if (writeresponsevalid) wresp_seen++;
    if (readdatavalid) rd_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (waitrequest !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_ready"}, 64'(waitrequest), 64'd0);
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input int bc, input logic [UW-1:0] usr,
                          input logic [7:0] be, input int gap_after, input logic [1:0] exp_resp);
    int seen0;
    wait_ready("wr");
    seen0 = wresp_seen;
    for (int i = 0; i < bc; i++) begin
      write      = 1'b1;
      read       = 1'b0;
      address    = (i == 0) ? addr : {AW{1'b1}};
      burstcount = (i == 0) ? BW'(bc) : 7'd1;
      user       = (i == 0) ? usr : ~usr;
      writedata  = wbuf[i];
      byteenable = be;
      tick();
      if (i == gap_after) begin
        write = 1'b0;
        tick();
        check("wr_gap_no_resp", 64'(writeresponsevalid), 64'd0);
        tick();
      end
    end
    write = 1'b0;
    check("wresp_valid", 64'(writeresponsevalid), 64'd1);
    check("wresp_code", 64'(writeresponse), 64'(exp_resp));
    check("wresp_user", 64'(writeresponseuser), 64'(usr));
    tick();
    check("wresp_pulse_width", 64'(writeresponsevalid), 64'd0);
    check("wresp_count", 64'(wresp_seen - seen0), 64'd1);
    $display("write addr=%h bc=%0d user=%h be=%h resp=%b", addr, bc, usr, be, writeresponse);
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input int bc, input logic [UW-1:0] usr,
                          input logic [1:0] exp_resp);
    wait_ready("rd");
    read       = 1'b1;
    write      = 1'b0;
    address    = addr;
    burstcount = BW'(bc);
    user       = usr;
    tick();
    read    = 1'b0;
    address = '0;
    user    = '0;
    for (int i = 0; i < bc; i++) begin
      check($sformatf("rd_valid[%0d]", i), 64'(readdatavalid), 64'd1);
      check($sformatf("rd_data[%0d]", i), readdata, ebuf[i]);
      check($sformatf("rd_resp[%0d]", i), 64'(response), 64'(exp_resp));
      check($sformatf("rd_user[%0d]", i), 64'(readresponseuser), 64'(usr));
      check($sformatf("rd_wait[%0d]", i), 64'(waitrequest), 64'd1);
      tick();
    end
    check("rd_end_valid", 64'(readdatavalid), 64'd0);
    check("rd_end_wait", 64'(waitrequest), 64'd0);
    $display("read addr=%h bc=%0d user=%h resp=%b", addr, bc, usr, exp_resp);
  endtask

  initial begin
    int n0;
    repeat (3) tick();
    check("rst_wait", 64'(waitrequest), 64'd1);
    check("rst_rdvalid", 64'(readdatavalid), 64'd0);
    check("rst_wrvalid", 64'(writeresponsevalid), 64'd0);
    check("rst_resp", 64'(response), 64'd0);
    check("rst_wresp", 64'(writeresponse), 64'd0);
    check("rst_rdata", readdata, 64'd0);
    check("rst_rduser", 64'(readresponseuser), 64'd0);
    check("rst_wruser", 64'(writeresponseuser), 64'd0);
    reset = 1'b0;
    check("post_rst_wait_hi", 64'(waitrequest), 64'd1);
    tick();
    check("post_rst_wait_lo", 64'(waitrequest), 64'd0);

    // Burst write then read-back at 0x10.
    wbuf[0] = 64'hA0A1_A2A3_A4A5_A6A7;
    wbuf[1] = 64'hB0B1_B2B3_B4B5_B6B7;
    wbuf[2] = 64'hC0C1_C2C3_C4C5_C6C7;
    wbuf[3] = 64'hD0D1_D2D3_D4D5_D6D7;
    wr_burst(27'h10, 4, 4'h5, 8'hFF, -1, 2'b00);
    for (int i = 0; i < 4; i++) ebuf[i] = wbuf[i];
    rd_burst(27'h10, 4, 4'hA, 2'b00);

    // Partial byte write over an all-ones word.
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_burst(27'h20, 1, 4'h1, 8'hFF, -1, 2'b00);
    wbuf[0] = 64'h0123_4567_89AB_CDEF;
    wr_burst(27'h20, 1, 4'h2, 8'h0F, -1, 2'b00);
    ebuf[0] = 64'hFFFF_FFFF_89AB_CDEF;
    rd_burst(27'h20, 1, 4'h3, 2'b00);

    // Burst wrapping past the top of the array.
    wbuf[0] = 64'h1111_1111_1111_1111;
    wbuf[1] = 64'h2222_2222_2222_2222;
    wbuf[2] = 64'h3333_3333_3333_3333;
    wr_burst(27'h3FE, 3, 4'h6, 8'hFF, -1, 2'b00);
    for (int i = 0; i < 3; i++) ebuf[i] = wbuf[i];
    rd_burst(27'h3FE, 3, 4'h7, 2'b00);

    // Out-of-range base address.
    ebuf[0] = '0;
    ebuf[1] = '0;
    rd_burst(27'h400, 2, 4'h8, 2'b10);
    wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    wr_burst(27'h400, 1, 4'h9, 8'hFF, -1, 2'b10);
    ebuf[0] = 64'h3333_3333_3333_3333;
    rd_burst(27'h000, 1, 4'hB, 2'b00);

    // Write burst with a two-cycle stall between beats 1 and 2.
    wbuf[0] = 64'h4000_0000_0000_0000;
    wbuf[1] = 64'h4100_0000_0000_0001;
    wbuf[2] = 64'h4200_0000_0000_0002;
    wbuf[3] = 64'h4300_0000_0000_0003;
    wr_burst(27'h40, 4, 4'hC, 8'hFF, 1, 2'b00);
    for (int i = 0; i < 4; i++) ebuf[i] = wbuf[i];
    rd_burst(27'h40, 4, 4'hD, 2'b00);

    // Reset during the second cycle of an 8-beat read.
    wait_ready("rst_rd");
    read = 1'b1; address = 27'h10; burstcount = 7'd8; user = 4'h3;
    tick();
    read = 1'b0;
    check("mid_rd_beat0_valid", 64'(readdatavalid), 64'd1);
    check("mid_rd_beat0_data", readdata, 64'hA0A1_A2A3_A4A5_A6A7);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 64'(readdatavalid), 64'd0);
    check("mid_rst_wait", 64'(waitrequest), 64'd1);
    tick();
    reset = 1'b0;
    n0 = rd_seen;
    check("mid_rst_rel_valid", 64'(readdatavalid), 64'd0);
    check("mid_rst_rel_wait", 64'(waitrequest), 64'd1);
    tick();
    check("mid_rst_after_wait", 64'(waitrequest), 64'd0);
    check("mid_rst_after_valid", 64'(readdatavalid), 64'd0);
    repeat (4) tick();
    check("mid_rst_no_beats", 64'(rd_seen - n0), 64'd0);
    $display("read addr=%h bc=8 aborted by reset", 27'h10);

    ebuf[0] = 64'hA0A1_A2A3_A4A5_A6A7;
    ebuf[1] = 64'hB0B1_B2B3_B4B5_B6B7;
    ebuf[2] = 64'hC0C1_C2C3_C4C5_C6C7;
    ebuf[3] = 64'hD0D1_D2D3_D4D5_D6D7;
    rd_burst(27'h10, 4, 4'hE, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ofs_plat_avalon_mem_sink_responder.md
Name: ofs_plat_avalon_mem_sink_responder

Overview:
- Single-clock Avalon-MM sink endpoint: the responder for requests that a clock-crossing shim or an AFU source issues.
- Backed by an internal word array of 2**MEM_ADDR_WIDTH entries.
- Handles burst reads and writes and returns read data, read response, write response and user echo.
- Used as a memory model behind async shims in simulation and as an on-chip scratch target in synthesis.

Parameters:
ADDR_WIDTH, 27, word address width of the interface
DATA_WIDTH, 512, data width in bits; multiple of 8
BURST_CNT_WIDTH, 7, burstcount width; max legal burst 2**(BURST_CNT_WIDTH-1)
USER_WIDTH, 4, request user width, echoed on responses
MEM_ADDR_WIDTH, 10, log2 of backing array depth; must be <= ADDR_WIDTH

Ports:
clk  input  1  sole clock
reset  input  1  synchronous, active-high reset
waitrequest  output  1  back-pressure to source
address  input  ADDR_WIDTH  word address, sampled on first beat only
burstcount  input  BURST_CNT_WIDTH  beats in burst, sampled on first beat only
read  input  1  read request
write  input  1  write beat
writedata  input  DATA_WIDTH  write data
byteenable  input  DATA_WIDTH/8  byte mask per write beat
user  input  USER_WIDTH  request user, sampled on first beat
readdata  output  DATA_WIDTH  read data
readdatavalid  output  1  read beat valid
response  output  2  per-read-beat response, 00 OKAY / 10 SLVERR
readresponseuser  output  USER_WIDTH  user echo on read beats
writeresponsevalid  output  1  one pulse per write burst
writeresponse  output  2  write burst response
writeresponseuser  output  USER_WIDTH  user echo on write response

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values, all registered: waitrequest=1, readdatavalid=0, writeresponsevalid=0, response=0, writeresponse=0, readdata=0, both user echoes 0, state=IDLE.
- Array contents are not reset.
- Acceptance: a request or beat is accepted when (read||write) && !waitrequest.
- FSM states: IDLE, WR_BURST, RD_BURST.
- waitrequest: 0 in IDLE and WR_BURST; 1 in RD_BURST; 1 in the first cycle after reset deasserts, then 0.
- IDLE, write accepted:
  - Latch base address, burstcount (bc) and user; write beat 0.
  - bc==1: stay IDLE. Otherwise go to WR_BURST with beat counter=1.
- WR_BURST: each accepted write beat writes array[(base+i) mod depth] under byteenable. On the final beat (i==bc-1), return to IDLE.
  - Address, burstcount and user on non-first beats are ignored.
  - read asserted in WR_BURST is illegal: simulation $fatal.
- Write response: writeresponsevalid pulses for exactly 1 cycle, the cycle after the final beat is accepted. writeresponseuser = latched user.
  - IDLE may accept a new command in that same cycle.
- IDLE, read accepted: latch address, bc and user, then go to RD_BURST.
  - Beat i is presented with readdatavalid=1 on cycle N+1+i, where N is the acceptance cycle.
  - Beats are contiguous with no bubbles.
  - readdata = array[(base+i) mod depth]; readresponseuser = latched user.
  - After beat bc-1 is registered, return to IDLE. waitrequest drops on the same edge, so the next command can be accepted on cycle N+bc+1 at the earliest.
- Read-after-write ordering: a read accepted after the final write beat returns the written data.
- Out of range: a request whose address bits [ADDR_WIDTH-1:MEM_ADDR_WIDTH] are nonzero is flagged for the whole burst.
  - Reads return data 0 with response=10 on every beat.
  - Writes modify nothing; writeresponse=10.
  - Otherwise responses are 00.
- Wrap: burst addresses wrap modulo the array depth within range. The range check applies to the base address only.
- Illegal inputs:
  - read && write together in IDLE: write wins; simulation $fatal.
  - burstcount==0: treated as 1; simulation $fatal.
- Reset mid-operation: FSM returns to IDLE and all valids are 0 on the next cycle. No response is ever emitted for an aborted burst. Array writes already performed persist.
- Throughput:
  - Writes: 1 beat per cycle.
  - Reads: bc beats per bc+1 cycles, including the accept cycle.

Test Plan:
- Reset, then write burst bc=4 at addr 0x10, data D0..D3, byteenable all 1s, user=0x5:
  - writeresponsevalid pulses once, 1 cycle after beat 3, with writeresponse=00 and user=0x5.
  - Then read bc=4 at 0x10: readdatavalid on cycles N+1..N+4 with D0..D3, response 00, readresponseuser echoing the read's user. waitrequest=1 on cycles N+1..N+4.
- Single write to 0x20, byteenable=0x...0F (only low 4 bytes), over a word previously all 0xFF:
  - Read returns the low 4 bytes new and all other bytes 0xFF.
- Write burst bc=3 at 0x3FE with MEM_ADDR_WIDTH=10:
  - Writes land at 0x3FE, 0x3FF and 0x000; a read bc=3 at 0x3FE returns them in order.
- Read at address 0x400 (out of range), bc=2:
  - 2 beats with readdata=0 and response=10.
  - A write bc=1 to 0x400 gives writeresponse=10, and array entry 0x000 is unchanged.
- Write burst bc=4 with the source deasserting write for 2 cycles between beats 1 and 2:
  - 4 beats are accepted, exactly one write response is emitted, and the data is correct.
- Reset asserted on the 2nd cycle of a read burst bc=8:
  - readdatavalid=0 from the cycle after reset and stays 0.
  - waitrequest=1 during reset and for 1 cycle after, then 0.
  - A new read is serviced normally.
